// File: rtl/data_mem_arbiter_if.sv
// Bundles both requester ports and the shared memory port of data_mem_arbiter.
// The arbiter uses the slave view; requesters and the memory model use the master view.
// Pure wiring: no state, no latency.
interface data_mem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  // Requester 0: processor data port
  logic                  cpu_req;
  logic                  cpu_memwrite;
  logic [ADDR_WIDTH-1:0] cpu_data_address;
  logic [DATA_WIDTH-1:0] cpu_writedata;
  logic                  cpu_ack;
  logic                  cpu_err;
  // Requester 1: debug loader
  logic                  dbg_req;
  logic                  dbg_memwrite;
  logic [ADDR_WIDTH-1:0] dbg_data_address;
  logic [DATA_WIDTH-1:0] dbg_writedata;
  logic                  dbg_ack;
  logic                  dbg_err;
  // Shared response data and memory side
  logic [DATA_WIDTH-1:0] received_data;
  logic                  memwrite;
  logic                  memread;
  logic [ADDR_WIDTH-1:0] data_address;
  logic [DATA_WIDTH-1:0] writedata;
  logic [DATA_WIDTH-1:0] mem_readdata;
  logic                  mem_ready;

  modport slave (
    input  cpu_req, cpu_memwrite, cpu_data_address, cpu_writedata,
    input  dbg_req, dbg_memwrite, dbg_data_address, dbg_writedata,
    input  mem_readdata, mem_ready,
    output cpu_ack, cpu_err, dbg_ack, dbg_err,
    output received_data, memwrite, memread, data_address, writedata
  );

  modport master (
    output cpu_req, cpu_memwrite, cpu_data_address, cpu_writedata,
    output dbg_req, dbg_memwrite, dbg_data_address, dbg_writedata,
    output mem_readdata, mem_ready,
    input  cpu_ack, cpu_err, dbg_ack, dbg_err,
    input  received_data, memwrite, memread, data_address, writedata
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Arbitrates cpu and debug-loader accesses onto one data memory port (IDLE -> BUSY -> RESP).
// Latency: ack 3 cycles after req is sampled when mem_ready is high on the first BUSY cycle.
// Backpressure: mem_ready stretches BUSY up to TIMEOUT cycles, then err; new reqs only taken in IDLE.
// Option: define DATA_MEM_ARBITER_RR_EN for round-robin ties; default gives cpu fixed priority.
module data_mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              reset,
  data_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Counter value on the last permitted BUSY cycle.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  gnt_q, gnt_d;          // 0 = cpu, 1 = dbg
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  memread_q, memread_d;
  logic                  memwrite_q, memwrite_d;
  logic                  cpu_ack_q, cpu_ack_d;
  logic                  dbg_ack_q, dbg_ack_d;
  logic                  cpu_err_q, cpu_err_d;
  logic                  dbg_err_q, dbg_err_d;
`ifdef DATA_MEM_ARBITER_RR_EN
  logic                  last_grant_q, last_grant_d;
`endif

  logic any_req;
  logic win;

  assign any_req = bus.cpu_req | bus.dbg_req;

  // Pick the winner among current requests; only ties depend on the policy.
  always_comb begin
    win = 1'b0;
    if (bus.cpu_req && bus.dbg_req) begin
`ifdef DATA_MEM_ARBITER_RR_EN
      win = ~last_grant_q;
`else
      win = 1'b0;
`endif
    end else if (bus.dbg_req) begin
      win = 1'b1;
    end
  end

  // Next-state and next-output computation for the transfer FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    memread_d  = memread_q;
    memwrite_d = memwrite_q;
    cpu_ack_d  = 1'b0;
    dbg_ack_d  = 1'b0;
    cpu_err_d  = 1'b0;
    dbg_err_d  = 1'b0;
`ifdef DATA_MEM_ARBITER_RR_EN
    last_grant_d = last_grant_q;
`endif

    case (state_q)
      IDLE: begin
        memread_d  = 1'b0;
        memwrite_d = 1'b0;
        if (any_req) begin
          gnt_d      = win;
          we_d       = win ? bus.dbg_memwrite     : bus.cpu_memwrite;
          addr_d     = win ? bus.dbg_data_address : bus.cpu_data_address;
          wdata_d    = win ? bus.dbg_writedata    : bus.cpu_writedata;
          memread_d  = win ? ~bus.dbg_memwrite    : ~bus.cpu_memwrite;
          memwrite_d = win ? bus.dbg_memwrite     : bus.cpu_memwrite;
          cnt_d      = 8'd0;
          state_d    = BUSY;
`ifdef DATA_MEM_ARBITER_RR_EN
          last_grant_d = win;
`endif
        end
      end

      BUSY: begin
        // mem_ready takes precedence over a timeout landing on the same edge.
        if (bus.mem_ready) begin
          if (!we_q) begin
            rdata_d = bus.mem_readdata;
          end
          memread_d  = 1'b0;
          memwrite_d = 1'b0;
          cpu_ack_d  = ~gnt_q;
          dbg_ack_d  = gnt_q;
          state_d    = RESP;
        end else if (cnt_q == CNT_LAST) begin
          memread_d  = 1'b0;
          memwrite_d = 1'b0;
          cpu_err_d  = ~gnt_q;
          dbg_err_d  = gnt_q;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      RESP: begin
        memread_d  = 1'b0;
        memwrite_d = 1'b0;
        state_d    = IDLE;
      end

      default: begin
        memread_d  = 1'b0;
        memwrite_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset kills any in-flight access immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      cpu_ack_q  <= 1'b0;
      dbg_ack_q  <= 1'b0;
      cpu_err_q  <= 1'b0;
      dbg_err_q  <= 1'b0;
`ifdef DATA_MEM_ARBITER_RR_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      cpu_ack_q  <= cpu_ack_d;
      dbg_ack_q  <= dbg_ack_d;
      cpu_err_q  <= cpu_err_d;
      dbg_err_q  <= dbg_err_d;
`ifdef DATA_MEM_ARBITER_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign bus.memread       = memread_q;
  assign bus.memwrite      = memwrite_q;
  assign bus.data_address  = addr_q;
  assign bus.writedata     = wdata_q;
  assign bus.received_data = rdata_q;
  assign bus.cpu_ack       = cpu_ack_q;
  assign bus.dbg_ack       = dbg_ack_q;
  assign bus.cpu_err       = cpu_err_q;
  assign bus.dbg_err       = dbg_err_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: transaction table plus reset, tie and recovery sequences.
module tb_data_mem_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  data_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic          who;          // 0 = cpu, 1 = dbg
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            ready_at;     // BUSY cycle that sees mem_ready, 0 = never
    bit            drop;         // drop req after first BUSY cycle
    logic          exp_err;
    int            exp_strobes;
    int            exp_cycle;    // req cycle = 1
    logic [DW-1:0] exp_rd;
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic who, input logic we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                              input int ready_at, input bit drop, input logic exp_err,
                              input int exp_strobes, input int exp_cycle,
                              input logic [DW-1:0] exp_rd);
    vec_t v;
    v.who = who; v.we = we; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.ready_at = ready_at; v.drop = drop; v.exp_err = exp_err;
    v.exp_strobes = exp_strobes; v.exp_cycle = exp_cycle; v.exp_rd = exp_rd;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.cpu_req = 1'b0; bus.cpu_memwrite = 1'b0; bus.cpu_data_address = '0; bus.cpu_writedata = '0;
    bus.dbg_req = 1'b0; bus.dbg_memwrite = 1'b0; bus.dbg_data_address = '0; bus.dbg_writedata = '0;
    bus.mem_readdata = '0; bus.mem_ready = 1'b0;
  endtask

  // Runs one transfer from a negedge; observes every cycle on the negedge.
  task automatic run_txn(input vec_t v, input string tag);
    int strobes = 0;
    int cycle = 0;
    bit seen = 0, got_err = 0, got_who = 0;
    bit addr_bad = 0, wd_bad = 0, dir_bad = 0, other_bad = 0;
    idle_inputs();
    if (v.who == 1'b0) begin
      bus.cpu_req = 1'b1; bus.cpu_memwrite = v.we;
      bus.cpu_data_address = v.addr; bus.cpu_writedata = v.wdata;
      bus.dbg_data_address = 32'hFFFF_0000; bus.dbg_writedata = 32'hA5A5_A5A5;
    end else begin
      bus.dbg_req = 1'b1; bus.dbg_memwrite = v.we;
      bus.dbg_data_address = v.addr; bus.dbg_writedata = v.wdata;
      bus.cpu_data_address = 32'hEEEE_0000; bus.cpu_writedata = 32'h5A5A_5A5A;
    end
    bus.mem_readdata = v.rdata;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (bus.memread || bus.memwrite) begin
        strobes++;
        if (bus.data_address !== v.addr) addr_bad = 1;
        if (bus.writedata !== v.wdata) wd_bad = 1;
        if (bus.memwrite !== v.we || bus.memread !== !v.we) dir_bad = 1;
        bus.mem_ready = (v.ready_at != 0 && strobes == v.ready_at);
        if (v.drop) begin
          bus.cpu_req = 1'b0;
          bus.dbg_req = 1'b0;
        end
      end else begin
        bus.mem_ready = 1'b0;
      end
      if (bus.cpu_ack || bus.cpu_err || bus.dbg_ack || bus.dbg_err) begin
        seen = 1;
        cycle = c + 2;
        got_err = bus.cpu_err | bus.dbg_err;
        got_who = bus.dbg_ack | bus.dbg_err;
        other_bad = v.who ? (bus.cpu_ack | bus.cpu_err) : (bus.dbg_ack | bus.dbg_err);
        break;
      end
    end
    chk({tag, "_resp_seen"}, 64'(seen), 64'd1);
    chk({tag, "_grant"}, 64'(got_who), 64'(v.who));
    chk({tag, "_err"}, 64'(got_err), 64'(v.exp_err));
    chk({tag, "_other_silent"}, 64'(other_bad), 64'd0);
    chk({tag, "_strobe_cycles"}, 64'(strobes), 64'(v.exp_strobes));
    chk({tag, "_resp_cycle"}, 64'(cycle), 64'(v.exp_cycle));
    chk({tag, "_received_data"}, 64'(bus.received_data), 64'(v.exp_rd));
    chk({tag, "_addr_stable"}, 64'(addr_bad), 64'd0);
    chk({tag, "_wdata_stable"}, 64'(wd_bad), 64'd0);
    chk({tag, "_direction"}, 64'(dir_bad), 64'd0);
    bus.cpu_req = 1'b0;
    bus.dbg_req = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_pulse_one_cycle"},
        64'({bus.cpu_ack, bus.cpu_err, bus.dbg_ack, bus.dbg_err, bus.memread, bus.memwrite}), 64'd0);
  endtask

  vec_t tbl [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit any_resp;
    bit who;
    bit seen;
    logic exp_who;

    tbl[0] = mk(1'b0, 1'b0, 32'h1001_0004, 32'h0,         32'hDEAD_BEEF, 1,  0, 1'b0, 1,  3,  32'hDEAD_BEEF);
    tbl[1] = mk(1'b1, 1'b1, 32'h1001_0000, 32'h1234_5678, 32'hAAAA_AAAA, 4,  0, 1'b0, 4,  6,  32'hDEAD_BEEF);
    tbl[2] = mk(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 32'h5555_5555, 2,  0, 1'b0, 2,  4,  32'hDEAD_BEEF);
    tbl[3] = mk(1'b1, 1'b0, 32'h0000_0044, 32'h0,         32'h0BAD_F00D, 3,  0, 1'b0, 3,  5,  32'h0BAD_F00D);
    tbl[4] = mk(1'b0, 1'b0, 32'h0000_0080, 32'h0,         32'h1111_1111, 0,  0, 1'b1, 15, 17, 32'h0BAD_F00D);
    tbl[5] = mk(1'b0, 1'b0, 32'h0000_0084, 32'h0,         32'h600D_CAFE, 15, 0, 1'b0, 15, 17, 32'h600D_CAFE);
    tbl[6] = mk(1'b1, 1'b0, 32'h0000_0088, 32'h0,         32'h2222_2222, 0,  0, 1'b1, 15, 17, 32'h600D_CAFE);
    tbl[7] = mk(1'b0, 1'b0, 32'h0000_008C, 32'h0,         32'h7654_3210, 2,  1, 1'b0, 2,  4,  32'h7654_3210);

    // Reset state
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_memread", 64'(bus.memread), 64'd0);
    chk("rst_memwrite", 64'(bus.memwrite), 64'd0);
    chk("rst_ack_err", 64'({bus.cpu_ack, bus.cpu_err, bus.dbg_ack, bus.dbg_err}), 64'd0);
    chk("rst_received_data", 64'(bus.received_data), 64'd0);
    chk("rst_data_address", 64'(bus.data_address), 64'd0);
    chk("rst_writedata", 64'(bus.writedata), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Transaction table
    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset in the second BUSY cycle, with mem_ready idle-high afterwards
    idle_inputs();
    bus.cpu_req = 1'b1;
    bus.cpu_data_address = 32'h0000_0030;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_strobe_before", 64'(bus.memread), 64'd1);
    reset = 1'b1;
    #1;
    chk("midrst_strobes_async", 64'({bus.memread, bus.memwrite}), 64'd0);
    chk("midrst_received_data", 64'(bus.received_data), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.cpu_req = 1'b0;
    bus.mem_ready = 1'b1;
    any_resp = 0;
    repeat (5) begin
      @(negedge clk);
      any_resp |= bus.cpu_ack | bus.cpu_err | bus.dbg_ack | bus.dbg_err | bus.memread | bus.memwrite;
    end
    chk("midrst_no_resp", 64'(any_resp), 64'd0);
    run_txn(mk(1'b0, 1'b0, 32'h0000_0090, 32'h0, 32'h1357_9BDF, 1, 0, 1'b0, 1, 3, 32'h1357_9BDF), "recover");

    // Tie: both requesters held for four transfers, starting from reset
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    bus.cpu_req = 1'b1; bus.cpu_data_address = 32'h0000_0100;
    bus.dbg_req = 1'b1; bus.dbg_data_address = 32'h0000_0200;
    bus.mem_readdata = 32'h0000_0ABC;
    for (int t = 0; t < 4; t++) begin
      seen = 0;
      who = 0;
      for (int c = 0; c < 50 && !seen; c++) begin
        @(negedge clk);
        bus.mem_ready = bus.memread | bus.memwrite;
        if (bus.cpu_ack || bus.dbg_ack) begin
          seen = 1;
          who = bus.dbg_ack;
        end
      end
`ifdef DATA_MEM_ARBITER_RR_EN
      exp_who = (t % 2 == 1);
`else
      exp_who = 1'b0;
`endif
      chk($sformatf("tie%0d_seen", t), 64'(seen), 64'd1);
      chk($sformatf("tie%0d_grant", t), 64'(who), 64'(exp_who));
    end
    idle_inputs();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning width of all data buses.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning width of all address buses.
REQ-003 SHALL have parameter TIMEOUT, default 15, meaning the maximum BUSY cycles before abort (range 1..255).
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have ports cpu_req / dbg_req, input, 1 each, meaning requester 0 (processor data port) / requester 1 (debug loader) requests a transfer.
REQ-007 SHALL have ports cpu_memwrite / dbg_memwrite, input, 1 each, meaning 1 = write, 0 = read.
REQ-008 SHALL have ports cpu_data_address / dbg_data_address, input, ADDR_WIDTH each, meaning the transfer address.
REQ-009 SHALL have ports cpu_writedata / dbg_writedata, input, DATA_WIDTH each, meaning the write data.
REQ-010 SHALL have ports cpu_ack / dbg_ack, output, 1 each, meaning a one-cycle completion pulse.
REQ-011 SHALL have ports cpu_err / dbg_err, output, 1 each, meaning a one-cycle timeout pulse.
REQ-012 SHALL have port received_data, output, DATA_WIDTH, meaning the registered read data, valid with ack.
REQ-013 SHALL have ports memwrite / memread, output, 1 each, meaning the shared memory strobes.
REQ-014 SHALL have ports data_address / writedata, output, ADDR_WIDTH / DATA_WIDTH, meaning the shared memory address and write data.
REQ-015 SHALL have port mem_readdata, input, DATA_WIDTH, meaning the memory read data.
REQ-016 SHALL have port mem_ready, input, 1, meaning the memory completes the current access this cycle.

Function
REQ-017 SHALL implement FSM IDLE -> BUSY -> RESP -> IDLE; states IDLE, BUSY and RESP are the only legal states.
REQ-018 In IDLE with any req high, SHALL latch the winner's memwrite, address and writedata plus the grant id at the edge, then enter BUSY.
REQ-019 In BUSY, SHALL drive memread = ~latched_we and memwrite = latched_we from the latched values; both strobes SHALL be 0 in IDLE and RESP.
REQ-020 In BUSY, when mem_ready = 1 at an edge, SHALL capture mem_readdata (reads only; writes keep the previous value) into received_data and enter RESP.
REQ-021 In RESP, SHALL assert ack to the granted requester only, for exactly one cycle.
REQ-022 Minimum latency SHALL be 3 cycles from req sampled to ack (mem_ready high on the first BUSY cycle).
REQ-023 An 8-bit counter SHALL count BUSY cycles. On reaching TIMEOUT without mem_ready, the block SHALL drop the strobes, pulse err (not ack) to the granted requester in the RESP cycle, and leave received_data unchanged.
REQ-024 Requesters SHALL hold req and all request fields until ack/err. Deassertion of req during BUSY SHALL NOT abort the access; the access completes with ack.
REQ-025 New requests SHALL be ignored outside IDLE, giving a minimum 1-cycle IDLE gap between transfers.
REQ-026 If mem_ready and the timeout are reached in the same cycle, mem_ready SHALL win and the block SHALL respond with ack.
REQ-027 mem_ready outside BUSY SHALL be ignored.

Reset
REQ-028 Asserting reset SHALL immediately force the state to IDLE and set all outputs to 0: strobes, ack, err, received_data, data_address and writedata.
REQ-029 Reset SHALL clear the counter and the latched fields, and set last_grant to 1 (so cpu wins the first tie).
REQ-030 When reset is asserted mid-BUSY, the in-flight access SHALL be dropped and no ack or err SHALL be issued.

Configuration
REQ-031 Macro DATA_MEM_ARBITER_RR_EN SHALL select the arbitration policy.
REQ-032 With DATA_MEM_ARBITER_RR_EN defined, a tie SHALL be granted to the requester not in last_grant, and last_grant SHALL update on every grant.
REQ-033 With DATA_MEM_ARBITER_RR_EN not defined, a tie SHALL always be granted to cpu, and last_grant SHALL be absent.

Verification
REQ-034 cpu read addr 0x10010004, mem_ready on the 1st BUSY cycle, mem_readdata 0xDEADBEEF -> memread for 1 cycle, cpu_ack at cycle 3, received_data = 0xDEADBEEF, dbg_ack = 0.
REQ-035 dbg write addr 0x10010000, data 0x12345678, mem_ready after 4 cycles -> memwrite held 4 cycles with stable address and data, then dbg_ack for 1 cycle.
REQ-036 Both req held for 4 transfers -> grants cpu, dbg, cpu, dbg with RR_EN defined, and cpu ×4 without it.
REQ-037 mem_ready tied 0 with TIMEOUT = 15 -> strobes drop after 15 BUSY cycles, cpu_err pulses once, and cpu_ack never asserts.
REQ-038 Reset asserted in the 2nd BUSY cycle -> strobes go to 0 asynchronously, no ack or err, and a new request after release is served normally.
REQ-039 mem_ready and the timeout reached in the same cycle -> ack is asserted and err is not.
